// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field widths, the canonical +0 encoding and the
// reduction controller state type.
package fp16_pkg;

  localparam int FP16_W     = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } red_state_e;

endpackage

// File: rtl/fp16_reduce_ctrl_if.sv
// Element stream, adder request/response and result signals of the reduction
// controller; master is the controller side, slave the surrounding system.
interface fp16_reduce_ctrl_if #(
  parameter int LEN_W = 7
);
  import fp16_pkg::*;

  logic                start;
  logic [LEN_W-1:0]    len;
  logic [FP16_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [FP16_W-1:0]   add_a;
  logic [FP16_W-1:0]   add_b;
  logic                add_valid;
  logic [FP16_W-1:0]   add_result;
  logic                add_complete;
  logic [FP16_W-1:0]   sum;
  logic                sum_valid;
  logic                busy;
  logic                err;

  modport master (
    input  start, len, in_data, in_valid, add_result, add_complete,
    output in_ready, add_a, add_b, add_valid, sum, sum_valid, busy, err
  );

  modport slave (
    output start, len, in_data, in_valid, add_result, add_complete,
    input  in_ready, add_a, add_b, add_valid, sum, sum_valid, busy, err
  );

endinterface

// File: rtl/fp16_reduce_wdog.sv
// Adder-response watchdog: counts WAIT cycles and flags the TIMEOUT-th one.
module fp16_reduce_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fp16_reduce_ctrl.sv
// Sequences a length-prefixed FP16 stream through an external single-cycle adder.
// Define FP16_REDUCE_TIMEOUT_EN to abort a stalled adder wait and flag err.
module fp16_reduce_ctrl
  import fp16_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst,
  fp16_reduce_ctrl_if.master  bus
);

  if (((2 ** LEN_W) <= MAX_LEN) || (TIMEOUT < 1)) begin : g_param_err
    $error("fp16_reduce_ctrl: LEN_W too narrow for MAX_LEN or TIMEOUT < 1");
  end

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  red_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [FP16_W-1:0] acc_q, acc_d;
  logic [FP16_W-1:0] b_q, b_d;
  logic [FP16_W-1:0] sum_q, sum_d;
  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  count_inc;
  logic              timeout;

  assign len_in      = bus.len;
  assign len_clamped = (len_in > MAX_LEN_L) ? MAX_LEN_L : len_in;
  assign count_inc   = count_q + 1'b1;

`ifdef FP16_REDUCE_TIMEOUT_EN
  logic err_q, err_d;

  fp16_reduce_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ST_ISSUE),
    .run     (state_q == ST_WAIT),
    .expired (timeout)
  );

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && bus.start) begin
      err_d = 1'b0;
    end else if (state_q == ST_WAIT && !bus.add_complete && timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A completion always wins over a same-cycle watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = (len_clamped == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (bus.in_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.add_complete) begin
          state_d = (count_inc == len_q) ? ST_DONE : ST_LOAD;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_LOAD);
    bus.add_valid = (state_q == ST_ISSUE);
    bus.sum_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
    bus.add_a     = acc_q;
    bus.add_b     = b_q;
    bus.sum       = sum_q;
`ifdef FP16_REDUCE_TIMEOUT_EN
    bus.err       = err_q;
`else
    bus.err       = 1'b0;
`endif
  end

  // sum captures the accumulator value being committed on the edge into DONE.
  always_comb begin
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d   = len_clamped;
          count_d = '0;
          acc_d   = FP16_POS_ZERO;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) b_d = bus.in_data;
      end
      ST_WAIT: begin
        if (bus.add_complete) begin
          acc_d   = bus.add_result;
          count_d = count_inc;
        end
      end
      default: ;
    endcase
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      sum_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= FP16_POS_ZERO;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: doc/fp16_reduce_ctrl.md
# fp16_reduce_ctrl

Sequencing initiator for the team's single-cycle FP16 adder. It accepts a length-prefixed stream of FP16 elements and issues one add request per element to an external adder over the `data_valid`/`complete` interface. It keeps a running FP16 sum and emits the final sum with a one-cycle valid pulse. It sits between the vector-load path and the adder, and turns the adder into a reduction unit.

## Interface
- `MAX_LEN`, 64: maximum elements per reduction.
- `LEN_W`, 7: width of `len`; must satisfy 2^LEN_W > MAX_LEN.
- `TIMEOUT`, 15: maximum wait cycles for `add_complete` (used only with the macro).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin reduction; sampled only in IDLE.
- `len`  in  LEN_W  element count, sampled with `start`; values above MAX_LEN are clamped to MAX_LEN.
- `in_data`  in  16  FP16 element.
- `in_valid`  in  1  element valid.
- `in_ready`  out  1  element accept; high only in LOAD.
- `add_a`  out  16  adder operand 1 (accumulator).
- `add_b`  out  16  adder operand 2 (element).
- `add_valid`  out  1  adder request, single-cycle pulse.
- `add_result`  in  16  adder sum; valid while `add_complete` is high.
- `add_complete`  in  1  adder done pulse.
- `sum`  out  16  final sum; held until the next `start`.
- `sum_valid`  out  1  one-cycle done pulse.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky timeout flag; cleared on an accepted `start`.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: on `start`, latch `len`, set acc = 16'h0000 and count = 0. Go to LOAD, or to DONE if `len` == 0.
- LOAD: `in_ready` = 1. On `in_valid && in_ready`, latch `in_data` into the b register and go to ISSUE.
- ISSUE: `add_valid` = 1 for exactly this cycle; go to WAIT.
- WAIT: on `add_complete`, acc <= `add_result` and count <= count + 1. If count + 1 == len go to DONE, else go to LOAD.
- DONE: `sum_valid` = 1, `sum` <= acc; go to IDLE.
- `add_a` = acc and `add_b` = b register; both are held stable from ISSUE through WAIT.
- `add_complete` outside WAIT is ignored.
- `start` while busy is ignored.
- Reset values: every output 0, acc 0, count 0, state IDLE.
- `rst` mid-operation aborts the reduction immediately. The adder shares `rst`.

## Timing
- Minimum 3 cycles per element: handshake at cycle k, ISSUE at k+1, `add_complete` at k+2, next LOAD at k+3.
- With `start` at cycle 0 and `in_valid` held high:
  - handshakes occur at cycles 1, 4, …, 3N-2;
  - `sum_valid` is high at cycle 3N+1.
- `len` = 0: `sum_valid` is high at cycle 1 with `sum` = 16'h0000, and no `add_valid` is issued.
- `in_valid` gaps stretch LOAD with no other effect.
- `sum` is updated in the same edge that raises `sum_valid`.

## Configuration
- `FP16_REDUCE_TIMEOUT_EN` defined:
  - a wait counter runs in WAIT and clears on entry to WAIT;
  - if `add_complete` has not arrived by the end of the TIMEOUT-th WAIT cycle, set `err` = 1 and go to DONE, which emits the partial acc.
- `FP16_REDUCE_TIMEOUT_EN` undefined: WAIT blocks indefinitely, `err` is tied to 0, and no counter logic is present.

## Structure
- Shared package `fp16_pkg`:
  - `FP16_POS_ZERO` = 16'h0000;
  - the reduction state enum typedef;
  - the FP16 field-width constants.
- Sub-module `fp16_reduce_wdog`: the timeout counter, instantiated only under the macro.
- The adder is external. Test benches and integration pair this block with the existing FP16 adder through a wrapper.

## Test plan
- `len`=4, four elements of 16'h3C00, real adder → one `add_valid` per element, `sum` = 16'h4400, `sum_valid` at cycle 13.
- `len`=0 → `sum_valid` at cycle 1, `sum` = 16'h0000, `add_valid` never asserted, `busy` high only in cycle 1.
- Elements 16'h4000, 16'hC000 with 2-cycle `in_valid` gaps → `sum` = 16'h0000; `in_ready` is never high outside LOAD.
- `len`=3 of 16'h3C00 with a second `start` (`len`=1) pulsed at cycle 5 → second start ignored, `sum` = 16'h4200, `sum_valid` at cycle 10.
- Macro on, TIMEOUT=15, adder model never completes → `err` = 1 and `sum_valid` with `sum` = 16'h0000 at cycle 18; `err` clears on the next accepted `start`.
- `rst` asserted in WAIT → the following cycle all outputs are 0 and state is IDLE; a fresh `len`=1 reduction of 16'h3C00 then returns 16'h3C00.
